// File: rtl/display_pkg.sv
// Shared constants and types for the 4-digit display value controller.
// Segment patterns are active-low, bit0=a ... bit6=g.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam int unsigned BCD_MAX = 9999;

    // Five BCD nibbles cover the largest 16-bit input (65535).
    localparam int BCD_W = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/display_value_ctrl_if.sv
// Value/decimal-point input handshake of the display value controller.
// master = producer (application logic), slave = controller.
interface display_value_ctrl_if #(
    parameter int VALUE_BITS = 14
);
    logic [VALUE_BITS-1:0] value_in;
    logic [3:0]            dp_in;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output value_in,
        output dp_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  value_in,
        input  dp_in,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// One BCD digit to an active-low 7-segment pattern.
// Codes 10..15 are not BCD and show blank.
import display_pkg::*;

module bcd_to_seg7 (
    input  logic [3:0] bcd_in,
    output logic [6:0] seg_out
);

    // Pattern lookup, blank for anything that is not a decimal digit.
    always_comb begin
        seg_out = SEG_BLANK;
        case (bcd_in)
            4'd0:    seg_out = SEG_0;
            4'd1:    seg_out = SEG_1;
            4'd2:    seg_out = SEG_2;
            4'd3:    seg_out = SEG_3;
            4'd4:    seg_out = SEG_4;
            4'd5:    seg_out = SEG_5;
            4'd6:    seg_out = SEG_6;
            4'd7:    seg_out = SEG_7;
            4'd8:    seg_out = SEG_8;
            4'd9:    seg_out = SEG_9;
            default: seg_out = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_value_ctrl.sv
// Binary value -> BCD (sequential double-dabble) -> registered 4-digit patterns.
// Define DISPLAY_VALUE_CTRL_LZB_EN to blank leading zero digits 3..1.
import display_pkg::*;

module display_value_ctrl #(
    parameter int VALUE_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    display_value_ctrl_if.slave  in_if,
    output logic [6:0]           digit_0_out,
    output logic [6:0]           digit_1_out,
    output logic [6:0]           digit_2_out,
    output logic [6:0]           digit_3_out,
    output logic [3:0]           dp_out,
    output logic                 done,
    output logic                 overflow
);

    localparam int CNT_W = $clog2(VALUE_BITS);

    state_t                 state_q, state_d;
    logic [VALUE_BITS-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [BCD_W-1:0]       bcd_adj;
    logic [3:0]             dp_lat_q, dp_lat_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0][6:0]        digit_q, digit_d;
    logic [3:0][6:0]        seg_enc;
    logic [3:0]             dp_out_q, dp_out_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;

    for (genvar g = 0; g < 4; g++) begin : g_seg
        bcd_to_seg7 u_seg (
            .bcd_in  (bcd_q[4*g +: 4]),
            .seg_out (seg_enc[g])
        );
    end

    assign bcd_adj = bcd_adjust(bcd_q);

    assign in_if.in_ready = (state_q == IDLE);

    // Next-state, conversion step and output-load decisions.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        dp_lat_d   = dp_lat_q;
        ovf_pend_d = ovf_pend_q;
        cnt_d      = cnt_q;
        digit_d    = digit_q;
        dp_out_d   = dp_out_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_if.in_valid) begin
                    shift_d    = in_if.value_in;
                    bcd_d      = '0;
                    dp_lat_d   = ~in_if.dp_in;
                    ovf_pend_d = 32'(in_if.value_in) > BCD_MAX;
                    cnt_d      = CNT_W'(VALUE_BITS - 1);
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ovf_pend_q) begin
                    digit_d = {4{SEG_DASH}};
                end else begin
                    digit_d = seg_enc;
`ifdef DISPLAY_VALUE_CTRL_LZB_EN
                    if (bcd_q[15:12] == 4'd0) begin
                        digit_d[3] = SEG_BLANK;
                        if (bcd_q[11:8] == 4'd0) begin
                            digit_d[2] = SEG_BLANK;
                            if (bcd_q[7:4] == 4'd0) begin
                                digit_d[1] = SEG_BLANK;
                            end
                        end
                    end
`else
                    digit_d = seg_enc;
`endif
                end
                dp_out_d = dp_lat_q;
                ovf_d    = ovf_pend_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset to a blank display.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            dp_lat_q   <= 4'hF;
            ovf_pend_q <= 1'b0;
            cnt_q      <= '0;
            digit_q    <= {4{SEG_BLANK}};
            dp_out_q   <= 4'hF;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            dp_lat_q   <= dp_lat_d;
            ovf_pend_q <= ovf_pend_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            dp_out_q   <= dp_out_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign digit_0_out = digit_q[0];
    assign digit_1_out = digit_q[1];
    assign digit_2_out = digit_q[2];
    assign digit_3_out = digit_q[3];
    assign dp_out      = dp_out_q;
    assign done        = done_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_display_value_ctrl.sv
// Scoreboard bench for display_value_ctrl: driver pushes expected displays,
// a negedge monitor pops them on done and checks holding in between.
module tb_display_value_ctrl;

    localparam int VB = 14;
    localparam logic [6:0] PAT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [27:0] BLANK4 = {4{7'h7F}};

    typedef struct packed {
        logic [27:0] digits;
        logic [3:0]  dp;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] d0, d1, d2, d3;
    logic [3:0] dp_out;
    logic done, overflow;

    display_value_ctrl_if #(.VALUE_BITS(VB)) in_if ();

    display_value_ctrl #(.VALUE_BITS(VB)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (in_if),
        .digit_0_out (d0),
        .digit_1_out (d1),
        .digit_2_out (d2),
        .digit_3_out (d3),
        .dp_out      (dp_out),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int unsigned cyc = 0;
    logic rst_q = 1'b1;
    logic mon_en = 1'b0;
    exp_t q[$];
    exp_t shown;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, leading zeros where v < 10^i.
    function automatic logic [27:0] model_digits(input int unsigned v);
        logic [27:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        if (v > 9999) return {4{7'h3F}};
        for (int i = 0; i < 4; i++) begin
            r[i*7 +: 7] = PAT[(v / p) % 10];
`ifdef DISPLAY_VALUE_CTRL_LZB_EN
            if (i > 0 && v < p) r[i*7 +: 7] = 7'h7F;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    // Monitor: on done compare against the scoreboard, otherwise check hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("digits", {4'd0, d3, d2, d1, d0}, {4'd0, e.digits});
                    chk("dp_out", {28'd0, dp_out}, {28'd0, e.dp});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    chk("ready_with_done", {31'd0, in_if.in_ready}, 32'd1);
                    shown = e;
                end
            end else begin
                if (rst_q) begin
                    shown.digits = BLANK4;
                    shown.dp     = 4'hF;
                    shown.ovf    = 1'b0;
                end
                chk("hold_digits", {4'd0, d3, d2, d1, d0},
                    {4'd0, shown.digits});
                chk("hold_dp", {28'd0, dp_out}, {28'd0, shown.dp});
                chk("hold_ovf", {31'd0, overflow}, {31'd0, shown.ovf});
            end
        end
    end

    task automatic send(input int unsigned v, input logic [3:0] dp,
                        input bit expect_done);
        int budget;
        exp_t e;
        budget = 0;
        @(negedge clk);
        in_if.value_in = VB'(v);
        in_if.dp_in    = dp;
        in_if.in_valid = 1'b1;
        while (!in_if.in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_if.in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (expect_done) begin
            e.digits = model_digits(v);
            e.dp     = ~dp;
            e.ovf    = (v > 9999);
            e.cyc    = cyc + VB + 2;
            q.push_back(e);
        end
        @(negedge clk);
        in_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        shown.digits = BLANK4;
        shown.dp     = 4'hF;
        shown.ovf    = 1'b0;
        shown.cyc    = 0;
        rst            = 1'b1;
        in_if.value_in = VB'(123);
        in_if.dp_in    = 4'h0;
        in_if.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst            = 1'b0;
        in_if.in_valid = 1'b0;
        mon_en         = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_digits", {4'd0, d3, d2, d1, d0}, {4'd0, BLANK4});
        chk("rst_dp", {28'd0, dp_out}, 32'hF);
        chk("rst_ready", {31'd0, in_if.in_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        send(1234, 4'b0100, 1);
        drain();
        send(9999, 4'b0000, 1);
        send(10000, 4'b1111, 1);
        drain();
        send(42, 4'b0001, 1);
        send(0, 4'b0000, 1);
        send((1 << VB) - 1, 4'b1010, 1);
        drain();

        send(500, 4'b0010, 1);
        in_if.value_in = VB'(77);
        in_if.dp_in    = 4'b1000;
        in_if.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_not_ready", {31'd0, in_if.in_ready}, 32'd0);
        end
        send(77, 4'b1000, 1);
        drain();

        send(500, 4'b0000, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_digits", {4'd0, d3, d2, d1, d0}, {4'd0, BLANK4});
        chk("midrst_dp", {28'd0, dp_out}, 32'hF);
        chk("midrst_ready", {31'd0, in_if.in_ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            int unsigned v;
            if (i % 3 == 0) v = $urandom_range(0, 99);
            else v = $urandom_range(0, (1 << VB) - 1);
            send(v, 4'($urandom), 1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
